// File: rtl/sevenseg_pkg.sv
// Shared definitions for the seven-segment scanner: digit count, the
// active-low segment vector type and the glyph table, ordered {g,f,e,d,c,b,a}.
// A cleared bit lights a segment; SEG_BLANK turns every segment off.
package sevenseg_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [6:0] seg_t;

  localparam seg_t SEG_0     = 7'b1000000;
  localparam seg_t SEG_1     = 7'b1111001;
  localparam seg_t SEG_2     = 7'b0100100;
  localparam seg_t SEG_3     = 7'b0110000;
  localparam seg_t SEG_4     = 7'b0011001;
  localparam seg_t SEG_5     = 7'b0010010;
  localparam seg_t SEG_6     = 7'b0000010;
  localparam seg_t SEG_7     = 7'b1111000;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0010000;
  localparam seg_t SEG_DASH  = 7'b0111111;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage : sevenseg_pkg

// File: rtl/sevenseg_scanner_bcd_to_seg.sv
// Purpose: combinational BCD-to-seven-segment decoder, active-low outputs.
// Ports:   code_i (4-bit digit), blank_i (force all segments off), seg_o.
// Codes 10..15 render as a dash so a corrupt digit is visible, not silent.
module bcd_to_seg
  import sevenseg_pkg::*;
(
  input  logic [3:0] code_i,
  input  logic       blank_i,
  output seg_t       seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    if (blank_i) begin
      seg_o = SEG_BLANK;
    end else begin
      case (code_i)
        4'd0:    seg_o = SEG_0;
        4'd1:    seg_o = SEG_1;
        4'd2:    seg_o = SEG_2;
        4'd3:    seg_o = SEG_3;
        4'd4:    seg_o = SEG_4;
        4'd5:    seg_o = SEG_5;
        4'd6:    seg_o = SEG_6;
        4'd7:    seg_o = SEG_7;
        4'd8:    seg_o = SEG_8;
        4'd9:    seg_o = SEG_9;
        default: seg_o = SEG_DASH;
      endcase
    end
  end

endmodule : bcd_to_seg

// File: rtl/sevenseg_scanner.sv
// Purpose: drives a 4-digit common-anode multiplexed display from BCD digits,
//          snapshotting the digits once per frame so a frame never tears.
// Ports:   sys_clk, reset (sync, active high), bcd3..bcd0, si in;
//          an (anodes), seg {g..a}, dp out, all active low.
module sevenseg_scanner
  import sevenseg_pkg::*;
#(
  parameter int REFRESH_DIV   = 100000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic [3:0]            bcd3,
  input  logic [3:0]            bcd2,
  input  logic [3:0]            bcd1,
  input  logic [3:0]            bcd0,
  input  logic                  si,
  output logic [NUM_DIGITS-1:0] an,
  output seg_t                  seg,
  output logic                  dp
);

  localparam int              CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [1:0]       idx_q,     idx_d;
  logic [15:0]      snap_q,    snap_d;
  logic             si_snap_q, si_snap_d;
  logic             valid_q,   valid_d;

  // Scan sequencing. The very first active cycle only captures a snapshot;
  // after that, the snapshot refreshes exactly when idx wraps 3->0 so every
  // frame starts on fresh digits.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    snap_d    = snap_q;
    si_snap_d = si_snap_q;
    valid_d   = valid_q;
    if (!valid_q) begin
      snap_d    = {bcd3, bcd2, bcd1, bcd0};
      si_snap_d = si;
      valid_d   = 1'b1;
    end else if (cnt_q == CNT_MAX) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
      if (idx_q == 2'd3) begin
        snap_d    = {bcd3, bcd2, bcd1, bcd0};
        si_snap_d = si;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      snap_q    <= 16'h0000;
      si_snap_q <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      snap_q    <= snap_d;
      si_snap_q <= si_snap_d;
      valid_q   <= valid_d;
    end
  end

  // Leading-zero blanking chains downward from the thousands digit: a digit
  // blanks only if it and every more significant digit are zero.
  logic [NUM_DIGITS-1:0] lead_blank;
  always_comb begin
    lead_blank = '0;
    if (BLANK_LEADING) begin
      lead_blank[3] = (snap_q[15:12] == 4'd0);
      lead_blank[2] = lead_blank[3] && (snap_q[11:8] == 4'd0);
      lead_blank[1] = lead_blank[2] && (snap_q[7:4]  == 4'd0);
    end
  end

  logic [3:0] cur_digit;
  logic       cur_blank;
  always_comb begin
    cur_digit = snap_q[3:0];
    case (idx_q)
      2'd0: cur_digit = snap_q[3:0];
      2'd1: cur_digit = snap_q[7:4];
      2'd2: cur_digit = snap_q[11:8];
      2'd3: cur_digit = snap_q[15:12];
      default: cur_digit = snap_q[3:0];
    endcase
  end

  // Before the first snapshot the whole display is dark.
  assign cur_blank = !valid_q || lead_blank[idx_q];

  always_comb begin
    an = '1;
    if (!cur_blank) begin
      an[idx_q] = 1'b0;
    end
  end

  bcd_to_seg u_bcd_to_seg (
    .code_i  (cur_digit),
    .blank_i (cur_blank),
    .seg_o   (seg)
  );

  assign dp = ~(si_snap_q & (idx_q == 2'd0) & valid_q);

endmodule : sevenseg_scanner
